// File: rtl/verbus_arbiter.sv
// Two-requester Verbus arbiter, round-robin or fixed priority.
// Define VERBUS_ARB_TIMEOUT_EN to add the subordinate watchdog.
module verbus_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_wstrobe,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_wstrobe,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_address,
  output logic [3:0]  s_wstrobe,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   to_hit;

`ifdef VERBUS_ARB_TIMEOUT_EN
  localparam logic [15:0] WAIT_LIM = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_q, wait_d;
  logic        terr_q, terr_d;

  always_comb begin
    wait_d = wait_q;
    terr_d = terr_q;
    to_hit = (state_q != IDLE) && !s_ready
             && (wait_q == WAIT_LIM);
    if (state_q == IDLE) begin
      wait_d = '0;
    end else if (!s_ready) begin
      wait_d = wait_q + 16'd1;
    end
    if (to_hit) begin
      terr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_error = terr_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign to_hit        = 1'b0;
  assign timeout_error = 1'b0;
`endif

  // last_q = 1 means m1 won the previous arbitration
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          if ((ROUND_ROBIN != 0) && !last_q) begin
            state_d = GRANT1;
          end else begin
            state_d = GRANT0;
          end
        end else if (m0_valid) begin
          state_d = GRANT0;
        end else if (m1_valid) begin
          state_d = GRANT1;
        end
        if (state_d == GRANT0) begin
          last_d = 1'b0;
        end else if (state_d == GRANT1) begin
          last_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (s_ready || to_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    grant     = 2'b00;
    s_valid   = 1'b0;
    s_address = '0;
    s_wstrobe = '0;
    s_wdata   = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    unique case (state_q)
      GRANT0: begin
        grant     = 2'b01;
        s_valid   = m0_valid;
        s_address = m0_address;
        s_wstrobe = m0_wstrobe;
        s_wdata   = m0_wdata;
        m0_ready  = s_ready | to_hit;
        m0_rdata  = to_hit ? 32'hDEAD_BEEF : s_rdata;
      end
      GRANT1: begin
        grant     = 2'b10;
        s_valid   = m1_valid;
        s_address = m1_address;
        s_wstrobe = m1_wstrobe;
        s_wdata   = m1_wdata;
        m1_ready  = s_ready | to_hit;
        m1_rdata  = to_hit ? 32'hDEAD_BEEF : s_rdata;
      end
      default: ;
    endcase
  end

endmodule
